// File: rtl/pico_alu_if.sv
// pico_alu_if: operand/opcode/enable bundle into the ALU and
// registered result/zero back out to write-back and branch logic.
interface pico_alu_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output en, A, B, alu_op,
    input  result, zero
  );

  modport slave (
    input  en, A, B, alu_op,
    output result, zero
  );
endinterface

// File: rtl/pico_alu.sv
// pico_alu: 8-bit picoMIPS ALU, registered result and zero flag.
// Define ALU_SAT_EN for signed saturating ADD/SUB (default wraps).
module pico_alu #(
  parameter int WIDTH = 8
) (
  input logic       clk,
  input logic       reset,
  pico_alu_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int M  = WIDTH - 1;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] dif;
  logic [WIDTH-1:0] add_r;
  logic [WIDTH-1:0] sub_r;
  logic [WIDTH-1:0] f;
  logic [PW-1:0]    prod;

  assign a   = bus.A;
  assign b   = bus.B;
  assign sum = a + b;
  assign dif = a - b;

  // Low 2W bits of the sign-extended product equal the signed product.
  assign prod = {{WIDTH{a[M]}}, a} * {{WIDTH{b[M]}}, b};

`ifdef ALU_SAT_EN
  logic [WIDTH-1:0] smax;
  logic [WIDTH-1:0] smin;
  logic             add_ovf;
  logic             sub_ovf;

  assign smax = {1'b0, {M{1'b1}}};
  assign smin = {1'b1, {M{1'b0}}};

  assign add_ovf = (a[M] == b[M]) &&
                   (sum[M] != a[M]);
  assign sub_ovf = (a[M] != b[M]) &&
                   (dif[M] != a[M]);

  // On overflow the true result has A's sign.
  assign add_r = add_ovf ? (a[M] ? smin : smax) : sum;
  assign sub_r = sub_ovf ? (a[M] ? smin : smax) : dif;
`else
  assign add_r = sum;
  assign sub_r = dif;
`endif

  always_comb begin
    f = '0;
    case (bus.alu_op)
      3'b000:  f = add_r;
      3'b001:  f = prod[PW-1:WIDTH];
      3'b010:  f = sub_r;
      3'b011:  f = '0;
      3'b100:  f = a & b;
      3'b101:  f = a | b;
      3'b110:  f = a ^ b;
      3'b111:  f = b;
      default: f = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.result <= '0;
      bus.zero   <= 1'b1;
    end else if (bus.en) begin
      bus.result <= f;
      bus.zero   <= (f == '0);
    end
  end
endmodule

// File: tb/tb_pico_alu.sv
// tb_pico_alu: directed literal checks plus randomized traffic
// compared every cycle against an integer-arithmetic model.
module tb_pico_alu;
  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;
  logic [7:0] exp_res;
  logic       exp_zero;
  logic       model_ok;

  pico_alu_if #(.WIDTH(8)) bus ();

  pico_alu #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model_f(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [2:0] op
  );
    int sa;
    int sb;
    int r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (op)
      3'd0: r = sa + sb;
      3'd1: r = (sa * sb) >>> 8;
      3'd2: r = sa - sb;
      3'd4: r = int'(a & b);
      3'd5: r = int'(a | b);
      3'd6: r = int'(a ^ b);
      3'd7: r = int'(b);
      default: r = 0;
    endcase
`ifdef ALU_SAT_EN
    if (op == 3'd0 || op == 3'd2) begin
      if (r > 127)  r = 127;
      if (r < -128) r = -128;
    end
`endif
    return r[7:0];
  endfunction

  task automatic check(
    input string      name,
    input logic [7:0] got,
    input logic [7:0] exp
  );
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %02h want %02h",
                  name, got, exp);
  endtask

  always @(posedge clk) begin
    if (reset) begin
      exp_res  <= 8'h00;
      exp_zero <= 1'b1;
      model_ok <= 1'b1;
    end else if (bus.en) begin
      exp_res  <= model_f(bus.A, bus.B, bus.alu_op);
      exp_zero <= (model_f(bus.A, bus.B, bus.alu_op) == 8'h00);
    end
  end

  always @(negedge clk) begin
    if (model_ok === 1'b1) begin
      check("model_result", bus.result, exp_res);
      check("model_zero", {7'd0, bus.zero}, {7'd0, exp_zero});
    end
  end

  task automatic drive(
    input logic       r,
    input logic       e,
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [2:0] op
  );
    @(negedge clk);
    reset      = r;
    bus.en     = e;
    bus.A      = a;
    bus.B      = b;
    bus.alu_op = op;
  endtask

  task automatic op_lit(
    input string      name,
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [2:0] op,
    input logic [7:0] want
  );
    drive(1'b0, 1'b1, a, b, op);
    @(posedge clk);
    #1;
    check(name, bus.result, want);
    check({name, "_z"}, {7'd0, bus.zero},
          {7'd0, want == 8'h00});
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    model_ok = 1'b0;
    reset    = 1'b1;
    bus.en   = 1'b1;
    bus.A    = 8'h0A;
    bus.B    = 8'h05;
    bus.alu_op = 3'b000;
    @(posedge clk);
    #1;
    check("reset_res", bus.result, 8'h00);
    check("reset_z", {7'd0, bus.zero}, 8'h01);

    op_lit("add", 8'h0A, 8'h05, 3'b000, 8'h0F);
    op_lit("add_ff", 8'hFF, 8'h01, 3'b000, 8'h00);
    op_lit("mulh1", 8'h10, 8'h20, 3'b001, 8'h02);
    op_lit("mulh2", 8'hF0, 8'h20, 3'b001, 8'hFE);
    op_lit("mulh3", 8'h80, 8'h80, 3'b001, 8'h40);
    op_lit("mulh4", 8'hFF, 8'h01, 3'b001, 8'hFF);
    op_lit("rsvd", 8'h0A, 8'h05, 3'b011, 8'h00);
    op_lit("and", 8'hCC, 8'hAA, 3'b100, 8'h88);
    op_lit("or", 8'hCC, 8'hAA, 3'b101, 8'hEE);
    op_lit("xor", 8'hCC, 8'hAA, 3'b110, 8'h66);
    op_lit("passb", 8'hCC, 8'hAA, 3'b111, 8'hAA);
    op_lit("sub", 8'h05, 8'h0A, 3'b010, 8'hFB);
`ifdef ALU_SAT_EN
    op_lit("add_ovf", 8'h70, 8'h20, 3'b000, 8'h7F);
    op_lit("sub_ovf", 8'h80, 8'h01, 3'b010, 8'h80);
`else
    op_lit("add_ovf", 8'h70, 8'h20, 3'b000, 8'h90);
    op_lit("sub_ovf", 8'h80, 8'h01, 3'b010, 8'h7F);
`endif

    op_lit("hold_cap", 8'h0A, 8'h05, 3'b000, 8'h0F);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 8'($urandom), 8'($urandom),
            3'($urandom));
      @(posedge clk);
      #1;
      check("hold", bus.result, 8'h0F);
      check("hold_z", {7'd0, bus.zero}, 8'h00);
    end

    drive(1'b1, 1'b1, 8'h33, 8'h44, 3'b101);
    @(posedge clk);
    #1;
    check("reset_prio", bus.result, 8'h00);

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 49) == 0,
            $urandom_range(0, 3) != 0,
            8'($urandom), 8'($urandom),
            3'($urandom));
    end
    @(negedge clk);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
